dot_product_ctrl: RTL and testbench

// - Sequences a multi-beat dot product through the PEGroup lane array. The array holds PARA_DEG lanes, and each lane computes result = old_output + data0*data1, registered.
// - Accepts a job (start + length in beats) and streams operand beats into the array with valid/ready.
// - Feeds the running per-lane partial sums back as old_output, then presents the final lane sums with valid/ready.
// - Sits between the operand fetch logic and PEGroup; one job in flight at a time.

---
 rtl/dotp_pkg.sv | 20 ++
 rtl/dotp_beat_counter.sv | 26 ++
 rtl/dot_product_ctrl.sv | 125 ++++++++++++
 tb/tb_dot_product_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dotp_pkg.sv
// Shared types and default sizing for the dot-product sequencer.
// Optional lane reduction output is enabled with DOTP_REDUCE_EN.
package dotp_pkg;

   localparam int DOTP_DATA_WIDTH = 8;
   localparam int DOTP_PARA_DEG   = 3;
   localparam int DOTP_LEN_WIDTH  = 8;

   localparam int LANE_W = 2 * DOTP_DATA_WIDTH;
   localparam int VEC_W  = DOTP_PARA_DEG * DOTP_DATA_WIDTH;
   localparam int ACC_W  = DOTP_PARA_DEG * LANE_W;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN,
      OUT
   } dotp_state_e;

endpackage

// File: rtl/dotp_beat_counter.sv
// Remaining-beat counter: parallel load, decrement on demand, zero flag.
module dotp_beat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequences a multi-beat dot product through an external PEGroup lane array.
// Define DOTP_REDUCE_EN to add out_sum, the combinational sum of all result lanes.
module dot_product_ctrl
   import dotp_pkg::*;
#(
   parameter int DATA_WIDTH = DOTP_DATA_WIDTH,
   parameter int PARA_DEG   = DOTP_PARA_DEG,
   parameter int LEN_WIDTH  = DOTP_LEN_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [LEN_WIDTH-1:0]             len,
   output logic                             busy,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [PARA_DEG*DATA_WIDTH-1:0]   in_data0,
   input  logic [PARA_DEG*DATA_WIDTH-1:0]   in_data1,
   output logic                             pe_load_old_output,
   output logic [PARA_DEG*DATA_WIDTH-1:0]   pe_data0,
   output logic [PARA_DEG*DATA_WIDTH-1:0]   pe_data1,
   output logic [PARA_DEG*2*DATA_WIDTH-1:0] pe_old_output,
   input  logic [PARA_DEG*2*DATA_WIDTH-1:0] pe_result,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [PARA_DEG*2*DATA_WIDTH-1:0] out_result,
   output logic                             done
`ifdef DOTP_REDUCE_EN
   ,
   output logic [2*DATA_WIDTH+$clog2(PARA_DEG)-1:0] out_sum
`endif
);

   localparam int L_W = 2 * DATA_WIDTH;
   localparam int A_W = PARA_DEG * L_W;

   dotp_state_e          state, state_next;
   logic [LEN_WIDTH-1:0] remaining;
   logic                 remaining_zero;
   logic [A_W-1:0]       acc;
   logic                 first;
   logic                 inflight;
   logic                 fire;
   logic                 start_accept;

   assign start_accept = (state == IDLE) && start;
   assign fire         = in_valid && in_ready;

   dotp_beat_counter #(
      .WIDTH(LEN_WIDTH)
   ) u_beat_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (start_accept),
      .load_value(len),
      .dec       (fire),
      .count     (remaining),
      .zero      (remaining_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:  if (start) state_next = (len != '0) ? FEED : OUT;
         FEED:  if (fire && (remaining == LEN_WIDTH'(1))) state_next = DRAIN;
         DRAIN: state_next = OUT;
         OUT:   if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      in_ready  = (state == FEED) && !remaining_zero;
      out_valid = (state == OUT);
   end

   // Partial sums are taken straight from the PE output while a beat is in
   // flight, so consecutive beats chain without waiting for acc to update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         first    <= 1'b0;
         inflight <= 1'b0;
         done     <= 1'b0;
      end else begin
         inflight <= fire;
         done     <= (state == OUT) && out_ready;
         if (start_accept) begin
            first <= 1'b1;
         end else if (fire) begin
            first <= 1'b0;
         end
         if (start_accept && (len == '0)) begin
            acc <= '0;
         end else if (inflight) begin
            acc <= pe_result;
         end
      end
   end

   assign pe_load_old_output = fire;
   assign pe_data0           = fire ? in_data0 : '0;
   assign pe_data1           = fire ? in_data1 : '0;
   assign pe_old_output      = first ? '0 : (inflight ? pe_result : acc);
   assign out_result         = acc;

`ifdef DOTP_REDUCE_EN
   always_comb begin
      out_sum = '0;
      for (int unsigned i = 0; i < PARA_DEG; i++) begin
         out_sum += ($bits(out_sum))'(acc[i*L_W +: L_W]);
      end
   end
`endif

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl with a behavioural PEGroup; honours DOTP_REDUCE_EN.
module tb_dot_product_ctrl;
   import dotp_pkg::*;

   localparam int DW = DOTP_DATA_WIDTH;
   localparam int PD = DOTP_PARA_DEG;
   localparam int LW = DOTP_LEN_WIDTH;
   localparam int SW = LANE_W + $clog2(PD);

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [LW-1:0]    len;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [VEC_W-1:0] in_data0, in_data1;
   logic             pe_load_old_output;
   logic [VEC_W-1:0] pe_data0, pe_data1;
   logic [ACC_W-1:0] pe_old_output, pe_result;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_result;
   logic             done;
`ifdef DOTP_REDUCE_EN
   logic [SW-1:0]    out_sum;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int load_cnt = 0;
   logic [VEC_W-1:0] beats_a[$];
   logic [VEC_W-1:0] beats_b[$];

   always #5 clk = ~clk;

   dot_product_ctrl #(
      .DATA_WIDTH(DW),
      .PARA_DEG  (PD),
      .LEN_WIDTH (LW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .len               (len),
      .busy              (busy),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data0          (in_data0),
      .in_data1          (in_data1),
      .pe_load_old_output(pe_load_old_output),
      .pe_data0          (pe_data0),
      .pe_data1          (pe_data1),
      .pe_old_output     (pe_old_output),
      .pe_result         (pe_result),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_result        (out_result),
      .done              (done)
`ifdef DOTP_REDUCE_EN
      ,
      .out_sum           (out_sum)
`endif
   );

   // PEGroup stand-in: result = old_output + data0*data1 per lane, registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pe_result <= '0;
      end else begin
         for (int i = 0; i < PD; i++) begin
            pe_result[i*LANE_W +: LANE_W] <= pe_old_output[i*LANE_W +: LANE_W]
               + LANE_W'(pe_data0[i*DW +: DW]) * LANE_W'(pe_data1[i*DW +: DW]);
         end
      end
   end

   always @(negedge clk) if (pe_load_old_output) load_cnt = load_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VEC_W-1:0] vec3(input int a, input int b, input int c);
      logic [VEC_W-1:0] v;
      v = '0;
      v[0*DW +: DW] = DW'(a);
      v[1*DW +: DW] = DW'(b);
      v[2*DW +: DW] = DW'(c);
      return v;
   endfunction

   // Reference: plain per-lane sum of products over all beats, then mod 2^LANE_W
   function automatic logic [ACC_W-1:0] ref_dot();
      logic [ACC_W-1:0] r;
      logic [VEC_W-1:0] a, b;
      longint s;
      r = '0;
      for (int l = 0; l < PD; l++) begin
         s = 0;
         for (int k = 0; k < beats_a.size(); k++) begin
            a = beats_a[k];
            b = beats_b[k];
            s += longint'(a[l*DW +: DW]) * longint'(b[l*DW +: DW]);
         end
         r[l*LANE_W +: LANE_W] = LANE_W'(s % (longint'(1) << LANE_W));
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] ref_sum(input logic [ACC_W-1:0] r);
      longint s;
      s = 0;
      for (int l = 0; l < PD; l++) s += longint'(r[l*LANE_W +: LANE_W]);
      return SW'(s);
   endfunction

   task automatic start_job(input int n);
      beats_a.delete();
      beats_b.delete();
      start = 1'b1;
      len   = LW'(n);
      tick();
      start = 1'b0;
      len   = '0;
   endtask

   task automatic send_beat(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, output int waited);
      in_valid = 1'b1;
      in_data0 = a;
      in_data1 = b;
      waited   = 0;
      while (!in_ready && waited < 40) begin
         tick();
         waited++;
      end
      tick();
      in_valid = 1'b0;
      in_data0 = '0;
      in_data1 = '0;
      beats_a.push_back(a);
      beats_b.push_back(b);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
      in_data0 = '0; in_data1 = '0; out_ready = 1'b0;
      tick(); tick();
      n_cmp++; if ({busy, in_ready, out_valid, done} !== 4'b0) begin n_bad++;
         $display("FAIL reset_ctrl got %b want 0000", {busy, in_ready, out_valid, done}); end
      n_cmp++; if ({pe_load_old_output, pe_data0, pe_data1, pe_old_output} !== '0) begin n_bad++;
         $display("FAIL reset_pe got %h want 0", {pe_load_old_output, pe_data0, pe_data1, pe_old_output}); end
      reset = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle busy=%b want 0", busy); end
   endtask

   task automatic test_single();
      int w;
      logic [ACC_W-1:0] exp;
      start_job(1);
      send_beat(vec3(2, 3, 4), vec3(5, 6, 7), w);
      exp = ref_dot();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat1 out_valid=%b want 0", out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_lat2 out_valid=%b want 1", out_valid); end
      n_cmp++; if (out_result !== exp) begin n_bad++; $display("FAIL single_result got %h want %h", out_result, exp); end
`ifdef DOTP_REDUCE_EN
      n_cmp++; if (out_sum !== ref_sum(exp)) begin n_bad++; $display("FAIL single_sum got %0d want %0d", out_sum, ref_sum(exp)); end
`endif
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL single_done done,busy=%b want 10", {done, busy}); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse done=%b want 0", done); end
   endtask

   task automatic test_back_to_back();
      int w;
      int wsum;
      logic [ACC_W-1:0] exp;
      start_job(3);
      wsum = 0;
      for (int k = 0; k < 3; k++) begin
         send_beat(vec3(255, 255, 255), vec3(255, 255, 255), w);
         wsum += w;
      end
      exp = ref_dot();
      n_cmp++; if (wsum != 0) begin n_bad++; $display("FAIL b2b_stall waited %0d cycles want 0", wsum); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_result !== exp) begin n_bad++;
         $display("FAIL b2b_result valid=%b got %h want %h", out_valid, out_result, exp); end
`ifdef DOTP_REDUCE_EN
      n_cmp++; if (out_sum !== ref_sum(exp)) begin n_bad++; $display("FAIL b2b_sum got %0d want %0d", out_sum, ref_sum(exp)); end
`endif
      out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
   endtask

   task automatic test_gaps();
      int w, n;
      logic [ACC_W-1:0] exp;
      start_job(2);
      send_beat(vec3(1, 1, 1), vec3(2, 2, 2), w);
      tick(); tick(); tick();
      send_beat(vec3(3, 3, 3), vec3(4, 4, 4), w);
      exp = ref_dot();
      wait_valid(n);
      n_cmp++; if (n >= 40 || out_result !== exp) begin n_bad++;
         $display("FAIL gaps_result waited=%0d got %h want %h", n, out_result, exp); end
      out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
   endtask

   task automatic test_zero_len();
      int lc;
      lc = load_cnt;
      start_job(0);
      n_cmp++; if (out_valid !== 1'b1 || out_result !== '0) begin n_bad++;
         $display("FAIL zero_result valid=%b got %h want 1/0", out_valid, out_result); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      n_cmp++; if (done !== 1'b1 || load_cnt != lc) begin n_bad++;
         $display("FAIL zero_done done=%b loads=%0d want 1/0", done, load_cnt - lc); end
      tick();
   endtask

   task automatic test_out_stall();
      int w, n;
      logic [ACC_W-1:0] exp;
      start_job(1);
      send_beat(VEC_W'($urandom), VEC_W'($urandom), w);
      exp = ref_dot();
      wait_valid(n);
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         len   = (c == 2) ? LW'(2) : '0;
         n_cmp++; if (out_valid !== 1'b1 || out_result !== exp) begin n_bad++;
            $display("FAIL stall_hold c=%0d valid=%b got %h want %h", c, out_valid, out_result, exp); end
         tick();
      end
      start = 1'b0; len = '0;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done done=%b want 1", done); end
      tick();
      n_cmp++; if ({busy, in_ready} !== 2'b00) begin n_bad++;
         $display("FAIL stall_start_ignored busy,in_ready=%b want 00", {busy, in_ready}); end
   endtask

   task automatic test_reset_mid();
      int w, n;
      logic [ACC_W-1:0] exp;
      start_job(3);
      send_beat(vec3(9, 9, 9), vec3(9, 9, 9), w);
      reset = 1'b1;
      #1;
      n_cmp++; if ({busy, in_ready, out_valid} !== 3'b000) begin n_bad++;
         $display("FAIL rstmid_drop busy,in_ready,out_valid=%b want 000", {busy, in_ready, out_valid}); end
      tick();
      reset = 1'b0;
      tick();
      start_job(1);
      send_beat(vec3(1, 1, 1), vec3(1, 1, 1), w);
      exp = ref_dot();
      wait_valid(n);
      n_cmp++; if (n >= 40 || out_result !== exp) begin n_bad++;
         $display("FAIL rstmid_result got %h want %h", out_result, exp); end
      out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
   endtask

   task automatic test_random();
      int w, n, nb;
      logic [ACC_W-1:0] exp;
      for (int j = 0; j < 8; j++) begin
         nb = $urandom_range(1, 6);
         start_job(nb);
         for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_beat(VEC_W'({$urandom, $urandom}), VEC_W'({$urandom, $urandom}), w);
         end
         exp = ref_dot();
         wait_valid(n);
         n_cmp++; if (n >= 40 || out_result !== exp) begin n_bad++;
            $display("FAIL rand_result job=%0d len=%0d got %h want %h", j, nb, out_result, exp); end
`ifdef DOTP_REDUCE_EN
         n_cmp++; if (out_sum !== ref_sum(exp)) begin n_bad++;
            $display("FAIL rand_sum job=%0d got %0d want %0d", j, out_sum, ref_sum(exp)); end
`endif
         repeat ($urandom_range(0, 3)) tick();
         out_ready = 1'b1; tick(); out_ready = 1'b0;
         n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rand_done job=%0d done=%b want 1", j, done); end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gaps();
      test_zero_len();
      test_out_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
